apb_reg_slave: RTL and testbench

APB_REG_SLAVE -- requirements
Module: apb_reg_slave

---
 rtl/apb_reg_slave_if.sv | 23 ++
 rtl/apb_reg_slave.sv | 92 +++++++++
 tb/tb_apb_reg_slave.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_reg_slave_if.sv
// apb_reg_slave_if: APB bus bundle between a master and apb_reg_slave.
interface apb_reg_slave_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   paddr;
    logic                    psel;
    logic                    penable;
    logic                    pwrite;
    logic [DATA_WIDTH-1:0]   pwdata;
    logic [DATA_WIDTH/8-1:0] pstrb;
    logic                    pready;
    logic [DATA_WIDTH-1:0]   prdata;
    logic                    pslverr;
    modport master (
        output paddr, psel, penable, pwrite, pwdata, pstrb,
        input  pready, prdata, pslverr
    );
    modport slave (
        input  paddr, psel, penable, pwrite, pwdata, pstrb,
        output pready, prdata, pslverr
    );
endinterface

// File: rtl/apb_reg_slave.sv
// apb_reg_slave: APB register file with wait states, byte strobes,
// read-only hardware-fed registers and per-register write strobes.
module apb_reg_slave #(
    parameter int                    ADDR_WIDTH  = 8,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    NUM_REGS    = 8,
    parameter int                    WAIT_STATES = 0,
    parameter logic [NUM_REGS-1:0]   RO_MASK     = '0,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL   = '0
) (
    input  logic                           clk,
    input  logic                           reset,
    apb_reg_slave_if.slave                 apb,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] reg_in,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
    output logic [NUM_REGS-1:0]            wr_pulse
);
    localparam int NB = DATA_WIDTH / 8;
    localparam int AL = $clog2(NB);
    localparam logic [ADDR_WIDTH-1:0] LO_MASK = ADDR_WIDTH'((1 << AL) - 1);
    typedef enum logic {IDLE, ACCESS} state_t;
    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0]   regs_d [NUM_REGS];
    logic [NUM_REGS-1:0]     wr_pulse_q, wr_pulse_d;
    logic [ADDR_WIDTH-1:0]   idx;
    logic                    in_range, hit_ro, err, ready, commit;
    logic [DATA_WIDTH-1:0]   rd_val;

    assign idx      = apb.paddr >> AL;
    assign in_range = {1'b0, idx} < (ADDR_WIDTH+1)'(NUM_REGS);
    assign ready    = state_q == ACCESS && apb.psel && apb.penable && cnt_q == 4'(WAIT_STATES);
    assign err      = !in_range || |(apb.paddr & LO_MASK) || (apb.pwrite && hit_ro);
    assign commit   = ready && apb.pwrite && !err;

    assign apb.pready  = ready;
    assign apb.pslverr = ready && err;
    assign apb.prdata  = (ready && !apb.pwrite && !err) ? rd_val : '0;
    assign wr_pulse    = wr_pulse_q;

    always_comb begin
        hit_ro = 1'b0;
        rd_val = '0;
        for (int i = 0; i < NUM_REGS; i++)
            if (idx == ADDR_WIDTH'(i)) begin
                hit_ro = RO_MASK[i];
                rd_val = RO_MASK[i] ? reg_in[i*DATA_WIDTH +: DATA_WIDTH] : regs_q[i];
            end
    end

    // psel falling before pready abandons the transfer without committing
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == IDLE) begin
            if (apb.psel && !apb.penable) begin
                state_d = ACCESS;
                cnt_d   = '0;
            end
        end else if (!apb.psel || ready)
            state_d = IDLE;
        else if (apb.penable)
            cnt_d = cnt_q + 4'd1;
    end

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i]     = regs_q[i];
            wr_pulse_d[i] = commit && idx == ADDR_WIDTH'(i);
            for (int k = 0; k < NB; k++)
                if (wr_pulse_d[i] && apb.pstrb[k]) regs_d[i][k*8 +: 8] = apb.pwdata[k*8 +: 8];
        end
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            wr_pulse_q <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VAL;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wr_pulse_q <= wr_pulse_d;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
        end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_out
        assign reg_out[i*DATA_WIDTH +: DATA_WIDTH] = RO_MASK[i] ? reg_in[i*DATA_WIDTH +: DATA_WIDTH] : regs_q[i];
    end
endmodule

// File: tb/tb_apb_reg_slave.sv
// tb_apb_reg_slave: directed checks on a zero-wait slave (reg 3 read-only)
// and a three-wait slave with a nonzero reset value.
module tb_apb_reg_slave;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic [7:0]   paddr_v  [2];
    logic [31:0]  pwdata_v [2];
    logic [3:0]   pstrb_v  [2];
    logic [1:0]   psel_v, penable_v, pwrite_v;
    logic [255:0] reg_in0, reg_in3, reg_out0, reg_out3;
    logic [7:0]   wr0, wr3;
    int checks = 0;
    int passes = 0;

    apb_reg_slave_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) b0 ();
    apb_reg_slave_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) b3 ();
    assign b0.paddr   = paddr_v[0];
    assign b0.psel    = psel_v[0];
    assign b0.penable = penable_v[0];
    assign b0.pwrite  = pwrite_v[0];
    assign b0.pwdata  = pwdata_v[0];
    assign b0.pstrb   = pstrb_v[0];
    assign b3.paddr   = paddr_v[1];
    assign b3.psel    = psel_v[1];
    assign b3.penable = penable_v[1];
    assign b3.pwrite  = pwrite_v[1];
    assign b3.pwdata  = pwdata_v[1];
    assign b3.pstrb   = pstrb_v[1];

    apb_reg_slave #(.WAIT_STATES(0), .RO_MASK(8'h08)) dut0 (
        .clk(clk), .reset(reset), .apb(b0), .reg_in(reg_in0), .reg_out(reg_out0), .wr_pulse(wr0)
    );
    apb_reg_slave #(.WAIT_STATES(3), .RESET_VAL(32'h0000_5A5A)) dut3 (
        .clk(clk), .reset(reset), .apb(b3), .reg_in(reg_in3), .reg_out(reg_out3), .wr_pulse(wr3)
    );

    function automatic logic [31:0] sl(input logic [255:0] v, input int i);
        return v[i*32 +: 32];
    endfunction

    task automatic bus_idle();
        @(negedge clk);
        psel_v    = '0;
        penable_v = '0;
    endtask

    // w selects the slave: 0 = zero-wait, 1 = three-wait
    task automatic apb(input int w, input logic wr, input logic [7:0] a, input logic [31:0] d,
                       input logic [3:0] s, output int waits, output logic [31:0] rd,
                       output logic e, output logic early);
        @(negedge clk);
        psel_v[w]    = 1'b1;
        penable_v[w] = 1'b0;
        pwrite_v[w]  = wr;
        paddr_v[w]   = a;
        pwdata_v[w]  = d;
        pstrb_v[w]   = s;
        @(negedge clk);
        penable_v[w] = 1'b1;
        #1;
        waits = 0;
        early = 1'b0;
        while (!(w != 0 ? b3.pready : b0.pready) && waits < 20) begin
            early = early | (w != 0 ? (b3.prdata != 0 || b3.pslverr) : (b0.prdata != 0 || b0.pslverr));
            @(negedge clk);
            #1;
            waits++;
        end
        rd = w != 0 ? b3.prdata : b0.prdata;
        e  = w != 0 ? b3.pslverr : b0.pslverr;
    endtask

    task automatic test_reset();
        @(negedge clk);
        #1;
        checks++; if (b0.pready !== 1'b0) $display("FAIL rst_pready: got %b expected 0", b0.pready); else passes++;
        checks++; if (b0.prdata !== 32'h0) $display("FAIL rst_prdata: got %h expected 0", b0.prdata); else passes++;
        checks++; if (b0.pslverr !== 1'b0) $display("FAIL rst_pslverr: got %b expected 0", b0.pslverr); else passes++;
        checks++; if (wr0 !== 8'h00) $display("FAIL rst_wr_pulse: got %h expected 00", wr0); else passes++;
        checks++; if (sl(reg_out0, 2) !== 32'h0) $display("FAIL rst_reg2: got %h expected 0", sl(reg_out0, 2)); else passes++;
        checks++; if (sl(reg_out0, 3) !== 32'hDEAD_BEEF) $display("FAIL rst_ro_pass: got %h expected deadbeef", sl(reg_out0, 3)); else passes++;
        checks++; if (sl(reg_out3, 0) !== 32'h0000_5A5A) $display("FAIL rst_resetval: got %h expected 00005a5a", sl(reg_out3, 0)); else passes++;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_penable_idle();
        logic bad = 1'b0;
        @(negedge clk);
        psel_v[0] = 1'b1; penable_v[0] = 1'b1; pwrite_v[0] = 1'b1;
        paddr_v[0] = 8'h08; pwdata_v[0] = 32'hFFFF_FFFF; pstrb_v[0] = 4'hF;
        repeat (3) begin
            #1;
            bad = bad | b0.pready;
            @(negedge clk);
        end
        #1;
        checks++; if (bad !== 1'b0) $display("FAIL idle_penable_pready: got %b expected 0", bad); else passes++;
        checks++; if (wr0 !== 8'h00 || sl(reg_out0, 2) !== 32'h0) $display("FAIL idle_penable_write: got wr %h reg %h expected 00/0", wr0, sl(reg_out0, 2)); else passes++;
        bus_idle();
    endtask

    task automatic test_write_full();
        int w; logic [31:0] rd; logic e, early;
        apb(0, 1'b1, 8'h08, 32'hA5A5_1234, 4'hF, w, rd, e, early);
        checks++; if (w !== 0) $display("FAIL wr_latency: got %0d waits expected 0", w); else passes++;
        checks++; if (e !== 1'b0) $display("FAIL wr_pslverr: got %b expected 0", e); else passes++;
        @(negedge clk); #1;
        checks++; if (sl(reg_out0, 2) !== 32'hA5A5_1234) $display("FAIL wr_reg2: got %h expected a5a51234", sl(reg_out0, 2)); else passes++;
        checks++; if (wr0 !== 8'h04) $display("FAIL wr_pulse_on: got %h expected 04", wr0); else passes++;
        @(negedge clk); #1;
        checks++; if (wr0 !== 8'h00) $display("FAIL wr_pulse_off: got %h expected 00", wr0); else passes++;
        bus_idle();
    endtask

    task automatic test_strobe();
        int w; logic [31:0] rd; logic e, early;
        apb(0, 1'b1, 8'h04, 32'hFFFF_FFFF, 4'b0101, w, rd, e, early);
        apb(0, 1'b0, 8'h04, 32'h0, 4'h0, w, rd, e, early);
        checks++; if (sl(reg_out0, 1) !== 32'h00FF_00FF) $display("FAIL strb_reg1: got %h expected 00ff00ff", sl(reg_out0, 1)); else passes++;
        checks++; if (rd !== 32'h00FF_00FF) $display("FAIL strb_read: got %h expected 00ff00ff", rd); else passes++;
        apb(0, 1'b1, 8'h04, 32'h1234_5678, 4'h0, w, rd, e, early);
        @(negedge clk); #1;
        checks++; if (wr0 !== 8'h02) $display("FAIL strb0_pulse: got %h expected 02", wr0); else passes++;
        checks++; if (sl(reg_out0, 1) !== 32'h00FF_00FF) $display("FAIL strb0_reg1: got %h expected 00ff00ff", sl(reg_out0, 1)); else passes++;
        bus_idle();
    endtask

    task automatic test_errors();
        int w; logic [31:0] rd; logic e, early;
        apb(0, 1'b0, 8'h20, 32'h0, 4'h0, w, rd, e, early);
        checks++; if (e !== 1'b1 || w !== 0) $display("FAIL err_range: got err %b waits %0d expected 1/0", e, w); else passes++;
        checks++; if (rd !== 32'h0) $display("FAIL err_range_prdata: got %h expected 0", rd); else passes++;
        apb(0, 1'b1, 8'h02, 32'hFFFF_FFFF, 4'hF, w, rd, e, early);
        checks++; if (e !== 1'b1) $display("FAIL err_misaligned: got %b expected 1", e); else passes++;
        @(negedge clk); #1;
        checks++; if (wr0 !== 8'h00 || sl(reg_out0, 0) !== 32'h0) $display("FAIL err_nowrite: got wr %h reg0 %h expected 00/0", wr0, sl(reg_out0, 0)); else passes++;
        checks++; if (b0.pslverr !== 1'b0) $display("FAIL err_after: got %b expected 0", b0.pslverr); else passes++;
        bus_idle();
    endtask

    task automatic test_ro();
        int w; logic [31:0] rd; logic e, early;
        apb(0, 1'b1, 8'h0C, 32'h1111_2222, 4'hF, w, rd, e, early);
        checks++; if (e !== 1'b1) $display("FAIL ro_write_err: got %b expected 1", e); else passes++;
        @(negedge clk); #1;
        checks++; if (wr0 !== 8'h00) $display("FAIL ro_pulse: got %h expected 00", wr0); else passes++;
        apb(0, 1'b0, 8'h0C, 32'h0, 4'h0, w, rd, e, early);
        checks++; if (rd !== 32'hDEAD_BEEF || e !== 1'b0) $display("FAIL ro_read: got %h err %b expected deadbeef/0", rd, e); else passes++;
        bus_idle();
    endtask

    task automatic test_wait_states();
        int w; logic [31:0] rd; logic e, early;
        apb(1, 1'b0, 8'h00, 32'h0, 4'h0, w, rd, e, early);
        checks++; if (w !== 3) $display("FAIL ws_waits: got %0d expected 3", w); else passes++;
        checks++; if (early !== 1'b0) $display("FAIL ws_early_prdata: got %b expected 0", early); else passes++;
        checks++; if (rd !== 32'h0000_5A5A || e !== 1'b0) $display("FAIL ws_read: got %h err %b expected 00005a5a/0", rd, e); else passes++;
        bus_idle();
        #1;
        checks++; if (b3.pready !== 1'b0) $display("FAIL ws_pready_after: got %b expected 0", b3.pready); else passes++;
    endtask

    task automatic test_back_to_back();
        int w; logic [31:0] rd; logic e, early;
        apb(0, 1'b1, 8'h10, 32'h1111_1111, 4'hF, w, rd, e, early);
        apb(0, 1'b1, 8'h14, 32'h2222_2222, 4'hF, w, rd, e, early);
        checks++; if (w !== 0 || e !== 1'b0) $display("FAIL b2b_second: got waits %0d err %b expected 0/0", w, e); else passes++;
        apb(0, 1'b0, 8'h10, 32'h0, 4'h0, w, rd, e, early);
        checks++; if (rd !== 32'h1111_1111) $display("FAIL b2b_read4: got %h expected 11111111", rd); else passes++;
        apb(0, 1'b0, 8'h14, 32'h0, 4'h0, w, rd, e, early);
        checks++; if (rd !== 32'h2222_2222) $display("FAIL b2b_read5: got %h expected 22222222", rd); else passes++;
        bus_idle();
    endtask

    task automatic test_abort();
        int w; logic [31:0] rd; logic e, early;
        logic bad = 1'b0;
        @(negedge clk);
        psel_v[1] = 1'b1; penable_v[1] = 1'b0; pwrite_v[1] = 1'b1;
        paddr_v[1] = 8'h04; pwdata_v[1] = 32'h1234_5678; pstrb_v[1] = 4'hF;
        @(negedge clk);
        penable_v[1] = 1'b1;
        @(negedge clk);
        psel_v[1] = 1'b0; penable_v[1] = 1'b0;
        repeat (6) begin
            #1;
            bad = bad | (wr3 != 8'h00) | b3.pready;
            @(negedge clk);
        end
        checks++; if (bad !== 1'b0) $display("FAIL abort_activity: got %b expected 0", bad); else passes++;
        checks++; if (sl(reg_out3, 1) !== 32'h0000_5A5A) $display("FAIL abort_reg1: got %h expected 00005a5a", sl(reg_out3, 1)); else passes++;
        apb(1, 1'b1, 8'h04, 32'hCAFE_F00D, 4'hF, w, rd, e, early);
        checks++; if (w !== 3 || e !== 1'b0) $display("FAIL abort_next: got waits %0d err %b expected 3/0", w, e); else passes++;
        @(negedge clk); #1;
        checks++; if (wr3 !== 8'h02 || sl(reg_out3, 1) !== 32'hCAFE_F00D) $display("FAIL abort_next_write: got wr %h reg %h expected 02/cafef00d", wr3, sl(reg_out3, 1)); else passes++;
        bus_idle();
    endtask

    task automatic test_reset_mid();
        int w; logic [31:0] rd; logic e, early;
        @(negedge clk);
        psel_v[0] = 1'b1; penable_v[0] = 1'b0; pwrite_v[0] = 1'b1;
        paddr_v[0] = 8'h08; pwdata_v[0] = 32'h0BAD_F00D; pstrb_v[0] = 4'hF;
        @(negedge clk);
        reset = 1'b0;
        penable_v[0] = 1'b1;
        #1;
        checks++; if (b0.pready !== 1'b0 || b0.prdata !== 32'h0) $display("FAIL rstmid_outputs: got pready %b prdata %h expected 0/0", b0.pready, b0.prdata); else passes++;
        checks++; if (sl(reg_out0, 2) !== 32'h0 || wr0 !== 8'h00) $display("FAIL rstmid_cleared: got reg %h wr %h expected 0/00", sl(reg_out0, 2), wr0); else passes++;
        @(negedge clk);
        reset = 1'b1;
        psel_v = '0; penable_v = '0;
        @(negedge clk); #1;
        checks++; if (sl(reg_out0, 2) !== 32'h0 || wr0 !== 8'h00) $display("FAIL rstmid_nowrite: got reg %h wr %h expected 0/00", sl(reg_out0, 2), wr0); else passes++;
        apb(0, 1'b1, 8'h08, 32'h0BAD_F00D, 4'hF, w, rd, e, early);
        checks++; if (w !== 0 || e !== 1'b0) $display("FAIL rstmid_next: got waits %0d err %b expected 0/0", w, e); else passes++;
        @(negedge clk); #1;
        checks++; if (sl(reg_out0, 2) !== 32'h0BAD_F00D || wr0 !== 8'h04) $display("FAIL rstmid_next_write: got reg %h wr %h expected 0badf00d/04", sl(reg_out0, 2), wr0); else passes++;
        bus_idle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 8; i++) begin
            reg_in0[i*32 +: 32] = 32'hEEEE_0000 | 32'(i);
            reg_in3[i*32 +: 32] = 32'h7777_0000 | 32'(i);
        end
        reg_in0[3*32 +: 32] = 32'hDEAD_BEEF;
        psel_v = '0; penable_v = '0; pwrite_v = '0;
        for (int i = 0; i < 2; i++) begin
            paddr_v[i] = '0; pwdata_v[i] = '0; pstrb_v[i] = '0;
        end
        test_reset();
        test_penable_idle();
        test_write_full();
        test_strobe();
        test_errors();
        test_ro();
        test_wait_states();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
